// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared widths, op codes and state encoding for the memory sequencer.
package mem_seq_pkg;

  localparam int AW = 12;
  localparam int DW = 12;
  localparam logic [AW-1:0] AI_BASE = 12'o0010;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ISZ   = 2'b10,
    OP_IND   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/mem_seq_if.sv
// rtl/mem_seq_if.sv - CPU request/response bus between the processor and the memory sequencer.
interface mem_seq_if;
  import mem_seq_pkg::*;

  logic          req;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          skip;

  modport master (output req, op, addr, wdata, input busy, ack, rdata, skip);
  modport slave  (input req, op, addr, wdata, output busy, ack, rdata, skip);

endinterface

// File: rtl/mem_seq_arb.sv
// rtl/mem_seq_arb.sv - fixed-priority select between data-break and CPU requests.
module mem_seq_arb
  import mem_seq_pkg::*;
(
  input  logic          i_cpu_req,
  input  logic [1:0]    i_cpu_op,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_brk_req,
  input  logic [1:0]    i_brk_op,
  input  logic [AW-1:0] i_brk_addr,
  input  logic [DW-1:0] i_brk_wdata,
  output logic          o_req,
  output logic [1:0]    o_op,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output logic          o_src
);

  // Data break wins; a simultaneous CPU request simply stays pending.
  assign o_src   = i_brk_req;
  assign o_req   = i_brk_req | i_cpu_req;
  assign o_op    = i_brk_req ? i_brk_op    : i_cpu_op;
  assign o_addr  = i_brk_req ? i_brk_addr  : i_cpu_addr;
  assign o_wdata = i_brk_req ? i_brk_wdata : i_cpu_wdata;

endmodule

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - PDP-8 core memory cycle sequencer (READ, WRITE, ISZ, auto-index IND).
// Defining MEM_SEQ_BREAK_EN adds a data-break port that has priority over CPU requests.
module mem_seq
  import mem_seq_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  mem_seq_if.slave      cpu,
`ifdef MEM_SEQ_BREAK_EN
  input  logic          brk_req,
  input  logic [1:0]    brk_op,
  input  logic [AW-1:0] brk_addr,
  input  logic [DW-1:0] brk_wdata,
  output logic          brk_ack,
`endif
  output logic [AW-1:0] mem_rdaddress,
  output logic [AW-1:0] mem_wraddress,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q
);

  state_t        r_state;
  op_t           r_op;
  logic [AW-1:0] r_ma;
  logic [DW-1:0] r_mb;
  logic [DW-1:0] r_rdata;
  logic          r_skip;
  logic          r_done;
  logic          r_busy;

  logic          w_req;
  logic [1:0]    w_op;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] w_ai_off;
  logic          w_in_ai;
  logic          w_mod_write;
  logic [DW-1:0] w_inc;

`ifdef MEM_SEQ_BREAK_EN
  logic w_src;
  logic r_src;

  mem_seq_arb u_arb (
    .i_cpu_req   (cpu.req),
    .i_cpu_op    (cpu.op),
    .i_cpu_addr  (cpu.addr),
    .i_cpu_wdata (cpu.wdata),
    .i_brk_req   (brk_req),
    .i_brk_op    (brk_op),
    .i_brk_addr  (brk_addr),
    .i_brk_wdata (brk_wdata),
    .o_req       (w_req),
    .o_op        (w_op),
    .o_addr      (w_addr),
    .o_wdata     (w_wdata),
    .o_src       (w_src)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_src <= 1'b0;
    else if (r_state == S_IDLE && w_req)
      r_src <= w_src;
  end

  assign cpu.ack = r_done & ~r_src;
  assign brk_ack = r_done & r_src;
`else
  assign w_req   = cpu.req;
  assign w_op    = cpu.op;
  assign w_addr  = cpu.addr;
  assign w_wdata = cpu.wdata;
  assign cpu.ack = r_done;
`endif

  // Wrapping subtract keeps the window test correct for any AI_BASE.
  assign w_ai_off    = r_ma - AI_BASE;
  assign w_in_ai     = (w_ai_off < AW'(8));
  assign w_inc       = mem_q + DW'(1);
  assign w_mod_write = (r_op == OP_ISZ) || (r_op == OP_IND && w_in_ai);

  assign mem_rdaddress = r_ma;
  assign mem_wraddress = r_ma;
  assign mem_data      = (r_state == S_WR) ? r_mb : w_inc;
  assign mem_wren      = reset_n &&
                         ((r_state == S_MOD && w_mod_write) || r_state == S_WR);

  assign cpu.busy  = r_busy;
  assign cpu.rdata = r_rdata;
  assign cpu.skip  = r_skip;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_READ;
      r_ma    <= '0;
      r_mb    <= '0;
      r_rdata <= '0;
      r_skip  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_ma    <= w_addr;
            r_mb    <= w_wdata;
            r_op    <= op_t'(w_op);
            r_busy  <= 1'b1;
            r_state <= (w_op == OP_WRITE) ? S_WR : S_RD;
          end
        end
        S_RD: r_state <= S_MOD;
        S_MOD: begin
          r_rdata <= w_mod_write ? w_inc : mem_q;
          r_skip  <= (r_op == OP_ISZ) && (w_inc == '0);
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_WR: begin
          r_rdata <= r_mb;
          r_skip  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - directed and randomized checks of mem_seq against a word-level memory model.
module tb_mem_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] mem_rdaddress, mem_wraddress, mem_data, mem_q;
  logic        mem_wren;
  logic [11:0] ram     [4096];
  logic [11:0] ref_mem [4096];
  logic [11:0] last_rd = '0;
  logic [11:0] last_a = '0;
  int          checks = 0;
  int          errors = 0;

  mem_seq_if cpu_if ();

`ifdef MEM_SEQ_BREAK_EN
  logic        brk_req = 1'b0;
  logic [1:0]  brk_op = '0;
  logic [11:0] brk_addr = '0, brk_wdata = '0;
  logic        brk_ack;
`endif

  mem_seq dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu           (cpu_if),
`ifdef MEM_SEQ_BREAK_EN
    .brk_req       (brk_req),
    .brk_op        (brk_op),
    .brk_addr      (brk_addr),
    .brk_wdata     (brk_wdata),
    .brk_ack       (brk_ack),
`endif
    .mem_rdaddress (mem_rdaddress),
    .mem_wraddress (mem_wraddress),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .mem_q         (mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) ram[mem_wraddress] <= mem_data;
    mem_q <= ram[mem_rdaddress];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [11:0] a, input logic [11:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  // Word-level meaning of each op: returns result/skip/whether memory is written.
  task automatic model(input logic [1:0] o, input logic [11:0] a, input logic [11:0] d,
                       output logic [11:0] rd, output logic sk, output logic wr);
    int v;
    v  = (int'(ref_mem[a]) + 1) % 4096;
    sk = 1'b0;
    wr = 1'b0;
    rd = ref_mem[a];
    if (o == 2'b01) begin
      rd = d; wr = 1'b1;
    end else if (o == 2'b10) begin
      rd = 12'(v); wr = 1'b1; sk = (v == 0);
    end else if (o == 2'b11 && a >= 12'o0010 && a <= 12'o0017) begin
      rd = 12'(v); wr = 1'b1;
    end
    if (wr) ref_mem[a] = rd;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [11:0] a, input logic [11:0] d,
                       input bit hold);
    logic [11:0] exp_rd, wa, wd;
    logic        exp_sk, exp_wr;
    int          n, nwr;
    bit          got;
    @(negedge clock);
    chk("idle_busy", cpu_if.busy, 0);
    chk("rdata_held", cpu_if.rdata, last_rd);
    chk("ram_word", ram[last_a], ref_mem[last_a]);
    model(o, a, d, exp_rd, exp_sk, exp_wr);
    cpu_if.req = 1'b1; cpu_if.op = o; cpu_if.addr = a; cpu_if.wdata = d;
    @(posedge clock);
    n = 0; nwr = 0; got = 0; wa = '0; wd = '0;
    while (!got && n < 12) begin
      @(negedge clock);
      n++;
      if (!hold) begin
        cpu_if.req = 1'b0;
        cpu_if.op = 2'($urandom); cpu_if.addr = 12'($urandom); cpu_if.wdata = 12'($urandom);
      end
      if (n == 1) chk("busy", cpu_if.busy, 1);
      if (mem_wren) begin nwr++; wa = mem_wraddress; wd = mem_data; end
      if (cpu_if.ack) got = 1;
    end
    chk($sformatf("latency op%0d", o), n, (o == 2'b01) ? 2 : 3);
    chk($sformatf("rdata op%0d a%0o", o, a), cpu_if.rdata, exp_rd);
    chk("skip", cpu_if.skip, exp_sk);
    chk("wren_cycles", nwr, exp_wr ? 1 : 0);
    if (exp_wr) begin
      chk("wraddress", wa, a);
      chk("wrdata", wd, exp_rd);
    end
    last_rd = exp_rd;
    last_a  = a;
  endtask

  initial begin
    logic [11:0] r_a;
    logic [1:0]  r_o;
    cpu_if.req = 1'b0; cpu_if.op = '0; cpu_if.addr = '0; cpu_if.wdata = '0;
    for (int i = 0; i < 4096; i++) set_mem(12'(i), 12'($urandom));
    repeat (2) @(negedge clock);
    chk("rst_busy", cpu_if.busy, 0);
    chk("rst_ack", cpu_if.ack, 0);
    chk("rst_rdata", cpu_if.rdata, 0);
    chk("rst_skip", cpu_if.skip, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_rdaddr", mem_rdaddress, 0);
    reset_n = 1'b1;

    set_mem(12'o0200, 12'o1234);
    do_op(2'b00, 12'o0200, 12'o0, 0);
    do_op(2'b01, 12'o0300, 12'o4321, 0);
    do_op(2'b00, 12'o0300, 12'o0, 0);
    set_mem(12'o0400, 12'o7777);
    set_mem(12'o0401, 12'o0005);
    do_op(2'b10, 12'o0400, 12'o0, 0);
    do_op(2'b10, 12'o0401, 12'o0, 0);
    set_mem(12'o0012, 12'o0377);
    set_mem(12'o0020, 12'o0377);
    do_op(2'b11, 12'o0012, 12'o0, 0);
    do_op(2'b11, 12'o0020, 12'o0, 0);
    set_mem(12'o0017, 12'o7777);
    set_mem(12'o7777, 12'o7777);
    do_op(2'b11, 12'o0017, 12'o0, 0);
    do_op(2'b10, 12'o7777, 12'o0, 1);
    do_op(2'b10, 12'o7777, 12'o0, 0);

    // Reset while an ISZ is in its write-back cycle.
    @(negedge clock);
    set_mem(12'o0100, 12'o0055);
    cpu_if.req = 1'b1; cpu_if.op = 2'b10; cpu_if.addr = 12'o0100;
    @(posedge clock);
    @(negedge clock); cpu_if.req = 1'b0;
    @(negedge clock);
    chk("mod_wren", mem_wren, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_wren", mem_wren, 0);
    chk("abort_busy", cpu_if.busy, 0);
    chk("abort_ack", cpu_if.ack, 0);
    chk("abort_rdata", cpu_if.rdata, 0);
    chk("abort_skip", cpu_if.skip, 0);
    @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    chk("abort_mem", ram[12'o0100], 12'o0055);
    last_rd = '0;
    last_a  = 12'o0100;

    for (int k = 0; k < 40; k++) begin
      r_o = 2'($urandom);
      case ($urandom % 4)
        0: r_a = 12'o0010 + 12'($urandom % 8);
        1: r_a = (($urandom % 2) == 0) ? 12'o7777 : 12'o0007 + 12'(($urandom % 2) * 9);
        default: r_a = 12'($urandom);
      endcase
      if (($urandom % 3) == 0) set_mem(r_a, 12'o7777);
      do_op(r_o, r_a, 12'($urandom), ($urandom % 4) == 0);
      if (!cpu_if.req) repeat ($urandom % 3) @(negedge clock);
    end

`ifdef MEM_SEQ_BREAK_EN
    begin
      logic [11:0] b_rd, c_rd;
      logic        b_sk, c_sk, b_wr, c_wr;
      int          n, nb, nc;
      set_mem(12'o0500, 12'o0041);
      model(2'b10, 12'o0501, 12'o0, b_rd, b_sk, b_wr);
      model(2'b00, 12'o0500, 12'o0, c_rd, c_sk, c_wr);
      @(negedge clock);
      cpu_if.req = 1'b1; cpu_if.op = 2'b00; cpu_if.addr = 12'o0500;
      brk_req = 1'b1; brk_op = 2'b10; brk_addr = 12'o0501;
      @(posedge clock);
      n = 0; nb = 0; nc = 0;
      while (nc == 0 && n < 20) begin
        @(negedge clock);
        n++;
        brk_req = 1'b0;
        if (brk_ack) begin
          nb = n;
          chk("brk_rdata", cpu_if.rdata, b_rd);
          chk("brk_no_ack", cpu_if.ack, 0);
        end
        if (cpu_if.ack) begin
          nc = n;
          cpu_if.req = 1'b0;
          chk("cpu_after_brk_rdata", cpu_if.rdata, c_rd);
        end
      end
      chk("brk_latency", nb, 3);
      chk("cpu_after_brk_latency", nc, 7);
      last_rd = c_rd;
      last_a  = 12'o0501;
    end
`endif

    cpu_if.req = 1'b0;
    @(negedge clock);
    chk("final_busy", cpu_if.busy, 0);
    chk("final_rdata", cpu_if.rdata, last_rd);
    chk("final_ram", ram[last_a], ref_mem[last_a]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory-cycle sequencer sitting directly upstream of the 4K x 12 synchronous-read core RAM.
- Converts CPU memory requests into RAM read/write address, data and write-enable timing, and returns read data.
- Implements PDP-8 read-modify-write cycles: ISZ increment-and-write-back, and auto-index on indirect references to locations 0010-0017 (octal).
- One request in flight at a time; all core traffic passes through this block.

Parameters:
- AW, 12, address width (4K words).
- DW, 12, data word width.
- AI_BASE, 12'o0010, first auto-index location; the auto-index window is AI_BASE..AI_BASE+7.

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  CPU request, sampled only in IDLE.
- op  in  2  operation: 00 READ, 01 WRITE, 10 ISZ, 11 IND (indirect pointer fetch).
- addr  in  AW  memory address (MA).
- wdata  in  DW  write data (MB), used by WRITE only.
- busy  out  1  high whenever state != IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DW  result word, valid while ack=1 and held until the next ack.
- skip  out  1  ISZ result was 0000; valid with ack.
- mem_rdaddress  out  AW  RAM read address.
- mem_wraddress  out  AW  RAM write address.
- mem_data  out  DW  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DW  RAM registered read data, valid one clock after the address is presented.

Behaviour:
- States: IDLE, RD, MOD, WR, DONE.
- IDLE + req: latch MA=addr, MB=wdata, OP=op.
  - WRITE goes to WR; all other ops go to RD.
- RD: mem_rdaddress=MA; go to MOD. The RAM captures the address at the end of this cycle.
- MOD: mem_q is valid.
  - READ: rdata<=mem_q; no write.
  - ISZ: v=(mem_q+1) mod 4096. Drive mem_wren=1, mem_wraddress=MA, mem_data=v. rdata<=v; skip<=(v==0).
  - IND with MA in AI_BASE..AI_BASE+7: same increment and write-back as ISZ, rdata<=v, skip<=0.
  - IND outside that window: plain read.
  - All ops go to DONE.
- WR: mem_wren=1, mem_wraddress=MA, mem_data=MB; rdata<=MB; go to DONE.
- DONE: ack=1; go to IDLE.
- Latency from the req-accept edge:
  - ack in the 3rd cycle for READ, ISZ and IND.
  - ack in the 2nd cycle for WRITE.
- Back-to-back: the next req is accepted in the IDLE cycle after ack, so peak throughput is 1 op per 3 or 4 cycles.
- req during busy or DONE is ignored. A requester still holding req in IDLE after ack starts a new op.
- mem_rdaddress=MA at all times. mem_wren, mem_wraddress and mem_data are combinational from state; mem_wren=0 outside MOD-write and WR.
- Reset values: state=IDLE, MA=0, MB=0, OP=READ, rdata=0, skip=0, ack=0, busy=0, mem_wren=0.
- Reset asserted mid-cycle aborts immediately; mem_wren drops asynchronously and no partial write completes after reset.
- Wrap cases:
  - ISZ at 7777 writes 0000 with skip=1.
  - Auto-index at 7777 writes 0000 with skip=0.
  - Address 7777 is an ordinary location.

Optional Feature:
- Macro MEM_SEQ_BREAK_EN adds a data-break (DMA) port:
  - brk_req in 1, brk_op in 2, brk_addr in AW, brk_wdata in DW, brk_ack out 1.
  - brk_op encoding matches op; brk ISZ serves word-count and current-address increments.
- In IDLE, brk_req has priority over req when both are high in the same cycle.
- A SRC flag, latched at accept, steers the completion pulse to brk_ack or ack. rdata and skip are shared.
- A pending CPU req waits; it is never dropped.
- Without the macro, these ports and the arbitration logic are absent; behaviour is exactly as above.

Decomposition:
- mem_seq_pkg holds:
  - op codes: OP_READ, OP_WRITE, OP_ISZ, OP_IND.
  - the state enum.
  - AI_BASE and the constant DW/AW widths.
- Sub-module mem_seq_arb (two-requester fixed-priority select of addr/op/wdata plus the SRC flag) is instantiated only under MEM_SEQ_BREAK_EN. The core sequencer stays one module.

Test Plan:
- Preload mem[0200]=1234. READ 0200 -> ack 3 cycles after accept, rdata=1234, mem_wren never high.
- WRITE 0300 with data 4321 -> mem_wren=1 for one cycle with wraddress=0300, ack on the 2nd cycle; then READ 0300 returns 4321.
- mem[0400]=7777. ISZ 0400 -> write 0000, rdata=0000, skip=1. mem[0401]=0005: ISZ -> 0006, skip=0.
- mem[0012]=0377. IND 0012 -> writes 0400, rdata=0400. mem[0020]=0377: IND 0020 -> rdata=0377, no write.
- Assert reset_n low while in MOD of an ISZ -> mem_wren falls at once, location unchanged, outputs at reset values, busy=0.
- MEM_SEQ_BREAK_EN: req and brk_req high together -> brk served first (brk_ack pulse), CPU op completes next with ack and correct rdata.
